afg_param_bank: RTL and testbench
=================================

# afg_param_bank

Control-voltage parameter bank for the arbitrary function generator. It accepts 3-byte write frames from the host byte link and holds six 12-bit target values. Each output channel slews toward its target by a bounded step once per scan tick. The six slewed outputs drive the DAC scanner's `DC_OFFSET_Vin`, `DUTY_S_Vin`, `GAIN_V_Vin`, `SQ_VL_Vin`, `SQ_VT_Vin` and `Spare_Vin` inputs, so the sample-and-hold channels never see a full-scale jump inside one scan frame.

## Interface
Parameters:
- `STEP`, default 16: maximum output change per `Scan_Tick`, in LSBs, range 0..4095. 0 means the output jumps to the target on each tick.
- `TIMEOUT`, default 1000: idle cycles allowed between bytes of one frame before the frame is aborted. Must be ≥1.

Ports:
- `Clock` in 1: single clock.
- `Reset` in 1: synchronous, active-high.
- `Rx_Data` in 8: host byte.
- `Rx_Valid` in 1: `Rx_Data` valid this cycle.
- `Rx_Ready` out 1: constant 1; a byte is accepted on every cycle where `Rx_Valid` is high.
- `Scan_Tick` in 1: one-cycle pulse, once per scanner frame.
- `DC_OFFSET_Vin`, `DUTY_S_Vin`, `GAIN_V_Vin`, `SQ_VL_Vin`, `SQ_VT_Vin`, `Spare_Vin` out 12 each: slewed outputs, registered.
- `Write_Done` out 1: one-cycle pulse when a target is committed.
- `Frame_Err` out 1: one-cycle pulse on a malformed or timed-out frame.

## Operation
Frame format:
- Byte 0 (header) is `{4'hA, addr[3:0]}`.
  - addr 0..5 selects the channel, in output-port order.
  - Header `8'hA6` is a one-byte SNAP command.
- Byte 1 is `{4'h0, data[11:8]}`.
- Byte 2 is `data[7:0]`.

Parser states: IDLE, HDR, HI.
- IDLE, valid header with addr 0..5 → latch addr, go to HDR.
- IDLE, `8'hA6` → SNAP: every output is loaded with its target. Stay in IDLE.
- IDLE, any other byte → `Frame_Err`, stay in IDLE.
- HDR, byte with upper nibble 0 → latch `data[11:8]`, go to HI.
- HDR, byte with upper nibble nonzero → `Frame_Err`, go to IDLE.
- HI, any byte → `target[addr] <= {hi, byte}`, pulse `Write_Done`, go to IDLE.

Timeout:
- In HDR or HI, a gap counter counts cycles with `Rx_Valid` low.
- An accepted byte clears the counter.
- When the counter reaches `TIMEOUT`: go to IDLE, pulse `Frame_Err`, no commit.

Slew, applied per channel on a `Scan_Tick` cycle, using 13-bit arithmetic:
- `out < tgt`: `out <= min(out+STEP, tgt)`.
- `out > tgt`: `out <= max(out-STEP, tgt)`, clamped at 0.
- Equal: hold.
- `STEP==0`: `out <= tgt`.

Reset values:
- Targets and outputs: DC_OFFSET 12'h800, DUTY_S 12'h800, GAIN_V 12'h000, SQ_VL 12'h000, SQ_VT 12'hFFF, Spare 12'h000.
- Parser in IDLE, gap counter 0.
- `Write_Done` 0, `Frame_Err` 0.

## Timing
- A target updates on the clock edge that accepts byte 2. `Write_Done` is high in the following cycle.
- An output first moves on the first `Scan_Tick` edge after the commit edge.
  - A commit and a `Scan_Tick` in the same cycle: that tick slews toward the old target.
- SNAP and `Scan_Tick` in the same cycle: SNAP wins, and the output equals the target.
- The output settles from a full-scale step in at most ceil(4095/STEP) ticks.
- `Reset` asserted mid-frame: the partial frame is discarded and all registers return to their reset values on that edge.
- Back-to-back frames with no idle cycles are legal.

## Structure
- Shared package `afg_pkg`:
  - `HDR_TAG = 4'hA`, `SNAP_HDR = 8'hA6`, `NUM_CH = 6`.
  - Reset-default constant array.
  - Parser state enum.
- Sub-module `afg_slew_ch` holds one channel: target register, output register and step compare.
  - Parameters: `STEP` and `RST_VAL`.
  - Instantiated six times.
- The parser and gap counter live in the top level.

## Test plan
- Reset → outputs 800/800/000/000/FFF/000. `Rx_Ready`=1, no pulses.
- Frame A0,08,00 then 3 ticks with `STEP`=16 → `Write_Done` once. DC_OFFSET stays 800, since the target is already 800.
- Frame A2,0F,FF then ticks → GAIN_V reads 010, 020, … and reaches FFF on tick 256, then holds.
- Frame A4,00,00 then byte A6 → SQ_VT jumps FFF→000 at SNAP. The next tick causes no change.
- Header A2, then 1000 idle cycles → `Frame_Err` pulse. A following 01,23 produces no commit, and byte 01 raises `Frame_Err` as a bad header.
- Byte B1 → `Frame_Err`. Frame A7 → `Frame_Err`. Frame A1,10 → `Frame_Err` at byte 2. Reset asserted between bytes 1 and 2 → no commit, DUTY_S stays 800.

Source files
------------

// File: rtl/afg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : afg_pkg
//  Description : Shared constants, reset defaults and parser state encoding
//                for the AFG control-voltage parameter bank.
//  Revision    : 1.0 - initial release
// ============================================================================
package afg_pkg;

    localparam logic [3:0] HDR_TAG  = 4'hA;
    localparam logic [7:0] SNAP_HDR = 8'hA6;
    localparam int         NUM_CH   = 6;
    localparam int         DATA_W   = 12;

    // Per-channel power-on values, index = channel address:
    // 0 DC_OFFSET, 1 DUTY_S, 2 GAIN_V, 3 SQ_VL, 4 SQ_VT, 5 Spare
    localparam logic [NUM_CH-1:0][DATA_W-1:0] RST_DEFAULTS = {
        12'h000,    // Spare
        12'hFFF,    // SQ_VT
        12'h000,    // SQ_VL
        12'h000,    // GAIN_V
        12'h800,    // DUTY_S
        12'h800     // DC_OFFSET
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_HI   = 2'd2
    } parser_state_t;

endpackage
`default_nettype wire

// File: rtl/afg_slew_ch.sv
`default_nettype none
// ============================================================================
//  Module      : afg_slew_ch
//  Description : One parameter channel: target register, slewed output
//                register and the bounded-step compare logic.
//  Revision    : 1.0 - initial release
// ============================================================================
module afg_slew_ch
    import afg_pkg::*;
#(
    parameter int                 STEP    = 16,
    parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              snap,
    input  logic              tick,
    output logic [DATA_W-1:0] out_val
);

    // One extra bit of headroom so out+STEP and out-STEP never wrap silently
    localparam logic [DATA_W:0] C_STEP = (DATA_W+1)'(STEP);

    logic [DATA_W-1:0] r_target;
    logic [DATA_W-1:0] r_out;
    logic [DATA_W-1:0] w_next;
    logic [DATA_W:0]   w_out13;
    logic [DATA_W:0]   w_tgt13;
    logic [DATA_W:0]   w_up;
    logic [DATA_W:0]   w_dn;

    assign w_out13 = {1'b0, r_out};
    assign w_tgt13 = {1'b0, r_target};
    assign w_up    = w_out13 + C_STEP;
    assign w_dn    = w_out13 - C_STEP;

    // Next output value for one scan tick: move toward target by at most STEP
    always_comb begin
        w_next = r_out;
        if (C_STEP == '0) begin
            w_next = r_target;
        end else if (r_out < r_target) begin
            w_next = (w_up > w_tgt13) ? r_target : w_up[DATA_W-1:0];
        end else if (r_out > r_target) begin
            // Underflow below zero always lands on the target, which is >= 0
            w_next = ((w_out13 < C_STEP) || (w_dn < w_tgt13)) ? r_target : w_dn[DATA_W-1:0];
        end
    end

    // Target and output registers; SNAP overrides a coincident tick
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_target <= RST_VAL;
            r_out    <= RST_VAL;
        end else begin
            if (wr_en) begin
                r_target <= wr_data;
            end
            if (snap) begin
                r_out <= r_target;
            end else if (tick) begin
                r_out <= w_next;
            end
        end
    end

    assign out_val = r_out;

endmodule
`default_nettype wire

// File: rtl/afg_param_bank.sv
`default_nettype none
// ============================================================================
//  Module      : afg_param_bank
//  Description : Host byte-link frame parser with inter-byte timeout feeding
//                six slew-limited 12-bit control-voltage channels.
//  Revision    : 1.0 - initial release
// ============================================================================
module afg_param_bank
    import afg_pkg::*;
#(
    parameter int STEP    = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [7:0]        Rx_Data,
    input  logic              Rx_Valid,
    output logic              Rx_Ready,
    input  logic              Scan_Tick,
    output logic [DATA_W-1:0] DC_OFFSET_Vin,
    output logic [DATA_W-1:0] DUTY_S_Vin,
    output logic [DATA_W-1:0] GAIN_V_Vin,
    output logic [DATA_W-1:0] SQ_VL_Vin,
    output logic [DATA_W-1:0] SQ_VT_Vin,
    output logic [DATA_W-1:0] Spare_Vin,
    output logic              Write_Done,
    output logic              Frame_Err
);

    localparam int               GAP_W      = $clog2(TIMEOUT + 1);
    // The edge that closes the TIMEOUT-th idle cycle aborts the frame
    localparam logic [GAP_W-1:0] C_GAP_LAST = GAP_W'(TIMEOUT - 1);

    parser_state_t     r_state;
    parser_state_t     w_state_nx;
    logic [2:0]        r_addr;
    logic [2:0]        w_addr_nx;
    logic [3:0]        r_hi;
    logic [3:0]        w_hi_nx;
    logic [GAP_W-1:0]  r_gap;
    logic [GAP_W-1:0]  w_gap_nx;
    logic              r_write_done;
    logic              r_frame_err;
    logic              w_commit;
    logic              w_snap;
    logic              w_err;
    logic              w_timeout;

    logic [NUM_CH-1:0][DATA_W-1:0] w_ch_out;

    assign Rx_Ready  = 1'b1;
    assign w_timeout = (r_gap == C_GAP_LAST);

    // Parser next-state, frame decode and gap-counter update
    always_comb begin
        w_state_nx = r_state;
        w_addr_nx  = r_addr;
        w_hi_nx    = r_hi;
        w_gap_nx   = r_gap;
        w_commit   = 1'b0;
        w_snap     = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_gap_nx = '0;
                if (Rx_Valid) begin
                    if (Rx_Data == SNAP_HDR) begin
                        w_snap = 1'b1;
                    end else if ((Rx_Data[7:4] == HDR_TAG) && (Rx_Data[3:0] < 4'(NUM_CH))) begin
                        w_addr_nx  = Rx_Data[2:0];
                        w_state_nx = ST_HDR;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            ST_HDR: begin
                if (Rx_Valid) begin
                    w_gap_nx = '0;
                    if (Rx_Data[7:4] == 4'h0) begin
                        w_hi_nx    = Rx_Data[3:0];
                        w_state_nx = ST_HI;
                    end else begin
                        w_err      = 1'b1;
                        w_state_nx = ST_IDLE;
                    end
                end else if (w_timeout) begin
                    w_gap_nx   = '0;
                    w_err      = 1'b1;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_gap_nx = r_gap + 1'b1;
                end
            end
            ST_HI: begin
                if (Rx_Valid) begin
                    w_gap_nx   = '0;
                    w_commit   = 1'b1;
                    w_state_nx = ST_IDLE;
                end else if (w_timeout) begin
                    w_gap_nx   = '0;
                    w_err      = 1'b1;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_gap_nx = r_gap + 1'b1;
                end
            end
            default: begin
                w_gap_nx   = '0;
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Parser state, latched frame fields and registered status pulses
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_hi         <= '0;
            r_gap        <= '0;
            r_write_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_addr       <= w_addr_nx;
            r_hi         <= w_hi_nx;
            r_gap        <= w_gap_nx;
            r_write_done <= w_commit;
            r_frame_err  <= w_err;
        end
    end

    assign Write_Done = r_write_done;
    assign Frame_Err  = r_frame_err;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        afg_slew_ch #(
            .STEP    (STEP),
            .RST_VAL (RST_DEFAULTS[gi])
        ) u_ch (
            .Clock   (Clock),
            .Reset   (Reset),
            .wr_en   (w_commit && (r_addr == 3'(gi))),
            .wr_data ({r_hi, Rx_Data}),
            .snap    (w_snap),
            .tick    (Scan_Tick),
            .out_val (w_ch_out[gi])
        );
    end

    assign DC_OFFSET_Vin = w_ch_out[0];
    assign DUTY_S_Vin    = w_ch_out[1];
    assign GAIN_V_Vin    = w_ch_out[2];
    assign SQ_VL_Vin     = w_ch_out[3];
    assign SQ_VT_Vin     = w_ch_out[4];
    assign Spare_Vin     = w_ch_out[5];

endmodule
`default_nettype wire

// File: tb/tb_afg_param_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_afg_param_bank
//  Description : Scoreboard bench for afg_param_bank. Stimulus pushes the
//                expected pulses and output snapshots; a monitor pops and
//                compares whenever the DUT pulses or its outputs may change.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_afg_param_bank;

    localparam int EV_WD = 1;
    localparam int EV_FE = 2;

    logic        Clock;
    logic        Reset;
    logic [7:0]  Rx_Data;
    logic        Rx_Valid;
    logic        Rx_Ready;
    logic        Scan_Tick;
    logic [11:0] DC_OFFSET_Vin;
    logic [11:0] DUTY_S_Vin;
    logic [11:0] GAIN_V_Vin;
    logic [11:0] SQ_VL_Vin;
    logic [11:0] SQ_VT_Vin;
    logic [11:0] Spare_Vin;
    logic        Write_Done;
    logic        Frame_Err;

    afg_param_bank #(
        .STEP    (16),
        .TIMEOUT (1000)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .Rx_Data       (Rx_Data),
        .Rx_Valid      (Rx_Valid),
        .Rx_Ready      (Rx_Ready),
        .Scan_Tick     (Scan_Tick),
        .DC_OFFSET_Vin (DC_OFFSET_Vin),
        .DUTY_S_Vin    (DUTY_S_Vin),
        .GAIN_V_Vin    (GAIN_V_Vin),
        .SQ_VL_Vin     (SQ_VL_Vin),
        .SQ_VT_Vin     (SQ_VT_Vin),
        .Spare_Vin     (Spare_Vin),
        .Write_Done    (Write_Done),
        .Frame_Err     (Frame_Err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        string       name;
        logic [71:0] v;
    } snap_t;

    snap_t       snap_q[$];
    int          ev_q[$];
    logic [11:0] exp_v [6];
    int          checks   = 0;
    int          failures = 0;
    logic        seen_upd = 1'b0;
    logic        done_req = 1'b0;
    logic        done_ack = 1'b0;

    function automatic logic [71:0] pack_exp();
        return {exp_v[5], exp_v[4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]};
    endfunction

    // Outputs can only change on an edge with reset, tick or a SNAP byte
    always @(posedge Clock) begin
        seen_upd <= Reset || Scan_Tick || (Rx_Valid && (Rx_Data == 8'hA6));
    end

    // Monitor: pop and compare snapshots and pulses away from the active edge
    always @(negedge Clock) begin
        logic [71:0] act;
        snap_t       s;
        int          got;
        int          want;
        if (seen_upd) begin
            act = {Spare_Vin, SQ_VT_Vin, SQ_VL_Vin, GAIN_V_Vin, DUTY_S_Vin, DC_OFFSET_Vin};
            checks++;
            if (snap_q.size() == 0) begin
                failures++;
                $display("FAIL snapshot_unexpected: outputs=%h, no snapshot expected", act);
            end else begin
                s = snap_q.pop_front();
                if (act !== s.v) begin
                    failures++;
                    $display("FAIL %s: outputs=%h expected=%h", s.name, act, s.v);
                end
            end
            checks++;
            if (Rx_Ready !== 1'b1) begin
                failures++;
                $display("FAIL rx_ready: got %b expected 1", Rx_Ready);
            end
        end
        if ((Write_Done === 1'b1) || (Frame_Err === 1'b1)) begin
            got = (Write_Done === 1'b1 ? EV_WD : 0) + (Frame_Err === 1'b1 ? EV_FE : 0);
            checks++;
            if (ev_q.size() == 0) begin
                failures++;
                $display("FAIL pulse_unexpected: got kind %0d expected none", got);
            end else begin
                want = ev_q.pop_front();
                if (got != want) begin
                    failures++;
                    $display("FAIL pulse_kind: got kind %0d expected %0d", got, want);
                end
            end
        end
        if (done_req && !done_ack) begin
            checks++;
            if (ev_q.size() != 0) begin
                failures++;
                $display("FAIL pulses_missing: %0d pending expected 0", ev_q.size());
            end
            checks++;
            if (snap_q.size() != 0) begin
                failures++;
                $display("FAIL snapshots_missing: %0d pending expected 0", snap_q.size());
            end
            done_ack = 1'b1;
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic push_snap(input string nm);
        snap_t s;
        s.name = nm;
        s.v    = pack_exp();
        snap_q.push_back(s);
    endtask

    task automatic set_defaults();
        exp_v[0] = 12'h800; exp_v[1] = 12'h800; exp_v[2] = 12'h000;
        exp_v[3] = 12'h000; exp_v[4] = 12'hFFF; exp_v[5] = 12'h000;
    endtask

    task automatic rst_cycle();
        Reset = 1'b1;
        set_defaults();
        push_snap("reset_values");
        step();
        Reset = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int ev, input logic tk, input string nm);
        Rx_Valid  = 1'b1;
        Rx_Data   = b;
        Scan_Tick = tk;
        if (ev != 0) ev_q.push_back(ev);
        if (tk || (b == 8'hA6)) push_snap(nm);
        step();
        Rx_Valid  = 1'b0;
        Scan_Tick = 1'b0;
    endtask

    task automatic tick(input string nm);
        Scan_Tick = 1'b1;
        push_snap(nm);
        step();
        Scan_Tick = 1'b0;
    endtask

    initial begin
        int v;
        Reset     = 1'b1;
        Rx_Data   = 8'h00;
        Rx_Valid  = 1'b0;
        Scan_Tick = 1'b0;
        set_defaults();

        rst_cycle();
        rst_cycle();
        step();

        // DC_OFFSET rewritten with its current value: no movement
        send(8'hA0, 0, 1'b0, "");
        send(8'h08, 0, 1'b0, "");
        send(8'h00, EV_WD, 1'b0, "");
        for (int k = 0; k < 3; k++) tick("dc_hold");

        // GAIN_V full-scale ramp, 16 LSB per tick, settles on tick 256
        send(8'hA2, 0, 1'b0, "");
        send(8'h0F, 0, 1'b0, "");
        send(8'hFF, EV_WD, 1'b0, "");
        for (int k = 1; k <= 260; k++) begin
            exp_v[2] = (k >= 256) ? 12'hFFF : 12'(16 * k);
            tick("gain_ramp");
        end

        // SQ_VT target 0 then SNAP coincident with a tick: SNAP wins
        send(8'hA4, 0, 1'b0, "");
        send(8'h00, 0, 1'b0, "");
        send(8'h00, EV_WD, 1'b0, "");
        exp_v[4] = 12'h000;
        send(8'hA6, 0, 1'b1, "snap_with_tick");
        tick("after_snap");

        // Timeout after header, then stray bytes are bad headers
        send(8'hA2, 0, 1'b0, "");
        ev_q.push_back(EV_FE);
        repeat (1000) step();
        send(8'h01, EV_FE, 1'b0, "");
        send(8'h23, EV_FE, 1'b0, "");
        tick("after_timeout");

        // Malformed frames
        send(8'hB1, EV_FE, 1'b0, "");
        send(8'hA7, EV_FE, 1'b0, "");
        send(8'hA1, 0, 1'b0, "");
        send(8'h10, EV_FE, 1'b0, "");
        tick("after_bad_frames");

        // Reset between bytes 1 and 2 discards the frame
        send(8'hA1, 0, 1'b0, "");
        send(8'h0F, 0, 1'b0, "");
        rst_cycle();
        send(8'h34, EV_FE, 1'b0, "");
        tick("duty_after_reset");
        tick("duty_after_reset");

        // Commit with a coincident tick slews toward the old target
        send(8'hA0, 0, 1'b0, "");
        send(8'h0C, 0, 1'b0, "");
        send(8'h00, EV_WD, 1'b1, "commit_tick_old_target");
        exp_v[0] = 12'h810;
        tick("commit_next_tick");

        // Back-to-back frames with no idle cycle between them
        send(8'hA3, 0, 1'b0, "");
        send(8'h01, 0, 1'b0, "");
        send(8'h00, EV_WD, 1'b0, "");
        send(8'hA5, 0, 1'b0, "");
        send(8'h00, 0, 1'b0, "");
        send(8'h2A, EV_WD, 1'b0, "");
        for (int k = 1; k <= 17; k++) begin
            v = 16 * k;
            exp_v[3] = (v > 12'h100) ? 12'h100 : 12'(v);
            exp_v[5] = (v > 12'h02A) ? 12'h02A : 12'(v);
            exp_v[0] = 12'h810 + 12'(v);
            tick("back_to_back_ramp");
        end

        // Downward slew stopping on a target that is not a STEP multiple
        send(8'hA1, 0, 1'b0, "");
        send(8'h00, 0, 1'b0, "");
        send(8'h05, EV_WD, 1'b0, "");
        for (int k = 1; k <= 130; k++) begin
            v = 2048 - 16 * k;
            exp_v[1] = (v < 5) ? 12'h005 : 12'(v);
            v = 12'h920 + 16 * k;
            exp_v[0] = (v > 12'hC00) ? 12'hC00 : 12'(v);
            tick("duty_down");
        end

        step();
        step();
        done_req = 1'b1;
        for (int i = 0; (i < 10) && !done_ack; i++) @(negedge Clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
